// File: rtl/clk_divider_pkg.sv
// rtl/clk_divider_pkg.sv - shared constants for the runtime-programmable clock divider
//
// Purpose : holds the default ratio width used by the divider and its bus interface.
// Ports   : none (package).

package clk_divider_pkg;

   // Default width of DIV_RATIO and of the phase counter; supports N up to 255.
   localparam int DEF_RATIO_WD = 8;

endpackage : clk_divider_pkg

// File: rtl/clk_divider_if.sv
// rtl/clk_divider_if.sv - control/output bundle of the clock divider
//
// Purpose : groups the divider control inputs and the divided clock output.
// Signals : CLK_EN    - divider enable; 1 = divide, 0 = bypass
//           DIV_RATIO - unsigned division ratio N (RATIO_WD bits)
//           O_DIV_CLK - divided clock, or the reference clock in bypass
// Modports: master - software/clocking side driving the controls
//           slave  - the divider itself

interface clk_divider_if
   import clk_divider_pkg::*;
#(
   parameter int RATIO_WD = DEF_RATIO_WD
);

   logic                CLK_EN;
   logic [RATIO_WD-1:0] DIV_RATIO;
   logic                O_DIV_CLK;

   modport master (
      output CLK_EN,
      output DIV_RATIO,
      input  O_DIV_CLK
   );

   modport slave (
      input  CLK_EN,
      input  DIV_RATIO,
      output O_DIV_CLK
   );

endinterface : clk_divider_if

// File: rtl/clk_divider.sv
// rtl/clk_divider.sv - integer clock divider with runtime ratio and bypass
//
// Purpose : produces O_DIV_CLK with period N reference cycles (N = DIV_RATIO);
//           for odd N the low phase is one cycle longer than the high phase.
//           Passes the reference clock through when disabled or when N < 2.
// Ports   : I_REF_CLK - reference clock, all state updates on its rising edge
//           RST_EN    - synchronous active-low reset
//           bus       - clk_divider_if slave (CLK_EN, DIV_RATIO in; O_DIV_CLK out)

module clk_divider
   import clk_divider_pkg::*;
#(
   parameter int RATIO_WD = DEF_RATIO_WD
)
(
   input  logic          I_REF_CLK,
   input  logic          RST_EN,
   clk_divider_if.slave  bus
);

   logic [RATIO_WD-1:0] cnt;
   logic [RATIO_WD-1:0] half;
   logic [RATIO_WD-1:0] plen;
   logic [RATIO_WD-1:0] cnt_inc;
   logic                div_q;
   logic                active;

   // Phase length follows the current level: the low phase absorbs the odd
   // cycle. A new ratio takes effect at once; the >= compare lets a counter
   // that is already past a shortened phase toggle on the next edge.
   always_comb begin
      half    = bus.DIV_RATIO >> 1;
      active  = bus.CLK_EN && (bus.DIV_RATIO >= RATIO_WD'(2));
      plen    = div_q ? half : (half + {{(RATIO_WD-1){1'b0}}, bus.DIV_RATIO[0]});
      cnt_inc = cnt + RATIO_WD'(1);
   end

   // Held at zero whenever inactive so re-activation starts a fresh low phase.
   // cnt stays below plen (at most 128 for 8 bits), so cnt_inc cannot wrap.
   always_ff @(posedge I_REF_CLK) begin
      if (!RST_EN || !active) begin
         cnt   <= '0;
         div_q <= 1'b0;
      end else if (cnt_inc >= plen) begin
         cnt   <= '0;
         div_q <= ~div_q;
      end else begin
         cnt   <= cnt_inc;
      end
   end

   // Bypass mux: only glitch-free when controls are changed while quiescent.
   assign bus.O_DIV_CLK = active ? div_q : I_REF_CLK;

endmodule : clk_divider

// File: tb/tb_clk_divider.sv
// tb/tb_clk_divider.sv - self-checking testbench for clk_divider

module tb_clk_divider;

   localparam int WD = 8;

   logic clk;
   logic rst_en;

   clk_divider_if #(.RATIO_WD(WD)) bus ();

   clk_divider #(.RATIO_WD(WD)) dut (
      .I_REF_CLK (clk),
      .RST_EN    (rst_en),
      .bus       (bus)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: the level currently shown and how many reference
   // cycles it has been shown for (the cycle now starting included).
   int   m_lvl  = 0;
   int   m_held = 1;
   logic exp_hi, exp_lo;
   logic hi_s, lo_s;

   function automatic int phase_len(int lvl, int n);
      // low phase = ceil(N/2), high phase = floor(N/2)
      return lvl ? (n / 2) : (n - n / 2);
   endfunction

   // One reference cycle: advance model at the rising edge, then sample the
   // DUT output 1 ns into the high half and 1 ns into the low half.
   task automatic step();
      int  n;
      bit  act;
      @(posedge clk);
      n   = int'(bus.DIV_RATIO);
      act = bus.CLK_EN && (n >= 2);
      if (!rst_en || !act) begin
         m_lvl  = 0;
         m_held = 1;
      end else if (m_held >= phase_len(m_lvl, n)) begin
         m_lvl  = 1 - m_lvl;
         m_held = 1;
      end else begin
         m_held = m_held + 1;
      end
      exp_hi = act ? logic'(m_lvl) : 1'b1;
      exp_lo = act ? logic'(m_lvl) : 1'b0;
      #1 hi_s = bus.O_DIV_CLK;
      @(negedge clk);
      #1 lo_s = bus.O_DIV_CLK;
   endtask

   task automatic test_reset();
      rst_en = 1'b0;
      bus.CLK_EN = 1'b1;
      bus.DIV_RATIO = 8'd2;
      step();
      n_checks++;
      if (hi_s !== 1'b0 || lo_s !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_out got=%b%b exp=00", hi_s, lo_s);
      end
      n_checks++;
      if (hi_s !== exp_hi || lo_s !== exp_lo) begin
         n_fail++;
         $display("FAIL reset_model got=%b%b exp=%b%b", hi_s, lo_s, exp_hi, exp_lo);
      end
   endtask

   task automatic test_div2();
      rst_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         n_checks++;
         if (hi_s !== exp_hi || lo_s !== exp_lo) begin
            n_fail++;
            $display("FAIL div2 cyc=%0d got=%b%b exp=%b%b", i, hi_s, lo_s, exp_hi, exp_lo);
         end
         // divide-by-2 toggles every cycle, starting high after the reset cycle
         n_checks++;
         if (hi_s !== logic'((i + 1) % 2)) begin
            n_fail++;
            $display("FAIL div2_const cyc=%0d got=%b exp=%0d", i, hi_s, (i + 1) % 2);
         end
      end
   endtask

   task automatic test_div3_switch();
      int pre = $urandom_range(0, 3);
      for (int i = 0; i < pre; i++) step();
      bus.DIV_RATIO = 8'd3;
      for (int i = 0; i < 14; i++) begin
         step();
         n_checks++;
         if (hi_s !== exp_hi || lo_s !== exp_lo) begin
            n_fail++;
            $display("FAIL div3 cyc=%0d got=%b%b exp=%b%b", i, hi_s, lo_s, exp_hi, exp_lo);
         end
      end
   endtask

   task automatic test_div4_reset_div5();
      int lows, highs, guard;
      bus.DIV_RATIO = 8'd4;
      for (int i = 0; i < 10; i++) begin
         step();
         n_checks++;
         if (hi_s !== exp_hi || lo_s !== exp_lo) begin
            n_fail++;
            $display("FAIL div4 cyc=%0d got=%b%b exp=%b%b", i, hi_s, lo_s, exp_hi, exp_lo);
         end
      end
      rst_en = 1'b0;
      bus.DIV_RATIO = 8'd5;
      step();
      rst_en = 1'b1;
      lows = 1; highs = 0; guard = 0;
      while (guard < 40) begin
         step();
         guard++;
         n_checks++;
         if (hi_s !== exp_hi || lo_s !== exp_lo) begin
            n_fail++;
            $display("FAIL div5 cyc=%0d got=%b%b exp=%b%b", guard, hi_s, lo_s, exp_hi, exp_lo);
         end
         if (hi_s === 1'b0 && highs == 0) lows++;
         else if (hi_s === 1'b1) highs++;
         else break;
      end
      n_checks++;
      if (lows != 3 || highs != 2) begin
         n_fail++;
         $display("FAIL div5_phases low=%0d high=%0d exp low=3 high=2", lows, highs);
      end
   endtask

   task automatic test_bypass_ratio();
      bit first_low_ok;
      for (int r = 0; r < 2; r++) begin
         bus.DIV_RATIO = WD'(r);
         for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (hi_s !== 1'b1 || lo_s !== 1'b0) begin
               n_fail++;
               $display("FAIL bypass_n%0d cyc=%0d got=%b%b exp=10", r, i, hi_s, lo_s);
            end
         end
      end
      bus.DIV_RATIO = 8'd4;
      first_low_ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         n_checks++;
         if (hi_s !== exp_hi || lo_s !== exp_lo) begin
            n_fail++;
            $display("FAIL bypass_ret cyc=%0d got=%b%b exp=%b%b", i, hi_s, lo_s, exp_hi, exp_lo);
         end
         // first low phase of 2 cycles: the switch cycle plus one more
         if (i == 0 && hi_s !== 1'b0) first_low_ok = 1'b0;
         if (i == 1 && hi_s !== 1'b1) first_low_ok = 1'b0;
      end
      n_checks++;
      if (!first_low_ok) begin
         n_fail++;
         $display("FAIL bypass_first_low got=bad exp=2-cycle low");
      end
   endtask

   task automatic test_enable();
      bus.CLK_EN = 1'b0;
      bus.DIV_RATIO = 8'd6;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if (hi_s !== 1'b1 || lo_s !== 1'b0) begin
            n_fail++;
            $display("FAIL en_off cyc=%0d got=%b%b exp=10", i, hi_s, lo_s);
         end
      end
      bus.CLK_EN = 1'b1;
      for (int i = 0; i < 14; i++) begin
         step();
         n_checks++;
         if (hi_s !== exp_hi || lo_s !== exp_lo) begin
            n_fail++;
            $display("FAIL en_on cyc=%0d got=%b%b exp=%b%b", i, hi_s, lo_s, exp_hi, exp_lo);
         end
         // 3 low (enable cycle + 2) then 3 high, period 6
         n_checks++;
         if (hi_s !== logic'(((i + 1) % 6) >= 3)) begin
            n_fail++;
            $display("FAIL en_pattern cyc=%0d got=%b", i, hi_s);
         end
      end
   endtask

   task automatic test_max_ratio();
      int lows, highs, lows2, guard, seg;
      rst_en = 1'b0;
      bus.DIV_RATIO = 8'd255;
      step();
      rst_en = 1'b1;
      lows = 1; highs = 0; lows2 = 0; guard = 0; seg = 0;
      while (guard < 400 && seg < 3) begin
         step();
         guard++;
         n_checks++;
         if (hi_s !== exp_hi || lo_s !== exp_lo) begin
            n_fail++;
            $display("FAIL max cyc=%0d got=%b%b exp=%b%b", guard, hi_s, lo_s, exp_hi, exp_lo);
         end
         if (seg == 0) begin
            if (hi_s === 1'b0) lows++; else begin seg = 1; highs = 1; end
         end else if (seg == 1) begin
            if (hi_s === 1'b1) highs++; else begin seg = 2; lows2 = 1; end
         end else begin
            if (hi_s === 1'b0) lows2++; else seg = 3;
         end
      end
      n_checks++;
      if (lows != 128 || highs != 127 || lows2 != 128) begin
         n_fail++;
         $display("FAIL max_phases low=%0d high=%0d low2=%0d exp 128/127/128", lows, highs, lows2);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) bus.DIV_RATIO = WD'($urandom_range(0, 12));
         if ($urandom_range(0, 31) == 0) bus.CLK_EN = ~bus.CLK_EN;
         rst_en = ($urandom_range(0, 49) != 0);
         step();
         n_checks++;
         if (hi_s !== exp_hi || lo_s !== exp_lo) begin
            n_fail++;
            $display("FAIL random cyc=%0d n=%0d en=%b got=%b%b exp=%b%b",
                     i, bus.DIV_RATIO, bus.CLK_EN, hi_s, lo_s, exp_hi, exp_lo);
         end
      end
   endtask

   initial begin
      rst_en = 1'b0;
      bus.CLK_EN = 1'b0;
      bus.DIV_RATIO = '0;
      @(negedge clk);
      test_reset();
      test_div2();
      test_div3_switch();
      test_div4_reset_div5();
      test_bypass_ratio();
      test_enable();
      test_max_ratio();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_clk_divider
